// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBus request/response types plus the arbiter state encoding.
// Imported by the round-robin arbiter and its picker.
package cbus_rr_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } cbus_size_t;

    // len counts beats minus one, so a single-beat transfer has len = 0.
    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } cbus_len_t;

    typedef struct packed {
        logic                valid;
        logic                is_write;
        cbus_size_t          size;
        logic [ADDR_W-1:0]   addr;
        logic [STRB_W-1:0]   strobe;
        logic [DATA_W-1:0]   data;
        cbus_len_t           len;
    } cbus_req_t;

    typedef struct packed {
        logic                ready;
        logic                last;
        logic [DATA_W-1:0]   data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_valid at or after i_ptr,
// wrapping modulo NUM_INPUTS. Reusable for any rotating-priority scheduler.
module cbus_rr_arbiter_rr_pick
    import cbus_rr_arbiter_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    localparam int IDX_W      = idx_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] i_valid,
    input  logic [IDX_W-1:0]      i_ptr,
    output logic                  o_found,
    output logic [IDX_W-1:0]      o_idx
);

    int w_dist;
    int w_best;

    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it holding a previous value, which would infer a latch.
        o_found = 1'b0;
        o_idx   = '0;
        w_dist  = 0;
        w_best  = NUM_INPUTS;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_dist = (i + NUM_INPUTS - int'(i_ptr)) % NUM_INPUTS;
            if (i_valid[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one CBus master port among NUM_INPUTS requesters.
// Logical requester i lives in packed element NUM_INPUTS-1-i, so index 0 is the MSB slot.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    localparam int IDX_W      = idx_width(NUM_INPUTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_idx,
    output logic                         err
);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [7:0]         r_beat_cnt;
    logic               r_err;

    logic [NUM_INPUTS-1:0] w_valid;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick_idx;
    logic [IDX_W-1:0]      w_next_ptr;
    cbus_req_t             w_gnt_req;
    logic [7:0]            w_len;
    logic                  w_beat;
    logic                  w_done;
    logic                  w_err_len;
    logic                  w_err_over;
    logic                  w_err_drop;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_valid[i] = ireqs[NUM_INPUTS-1-i].valid;
        end
    end

    cbus_rr_arbiter_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_rr_pick (
        .i_valid (w_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_gnt_req = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_grant_idx == IDX_W'(i)) begin
                w_gnt_req = ireqs[NUM_INPUTS-1-i];
            end
        end
    end

    // Outputs key off the registered state, so an asynchronous reset silences them at once.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (r_state == BUSY) begin
            oreq = w_gnt_req;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (r_grant_idx == IDX_W'(i)) begin
                    iresps[NUM_INPUTS-1-i] = oresp;
                end
            end
        end
    end

    assign w_len      = w_gnt_req.len;
    assign w_beat     = (r_state == BUSY) && oresp.ready;
    assign w_done     = w_beat && oresp.last;
    assign w_err_len  = w_done && (r_beat_cnt != w_len);
    assign w_err_over = w_beat && !oresp.last && (r_beat_cnt >= w_len);
    assign w_err_drop = (r_state == BUSY) && !w_gnt_req.valid;
    assign w_next_ptr = (r_grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0
                                                                 : r_grant_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_err_len || w_err_over || w_err_drop) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= BUSY;
                        r_grant_idx <= w_pick_idx;
                        r_beat_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                    if (w_done) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state == BUSY);
    assign grant_idx = r_grant_idx;
    assign err       = r_err;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scenario bench for cbus_rr_arbiter: grants and response beats are predicted into
// queues as stimulus is driven and retired by a negedge monitor.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int NUM   = 2;
    localparam int IDX_W = 1;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
    } exp_beat_t;

    logic                  clk = 1'b0;
    logic                  reset;
    cbus_req_t  [NUM-1:0]  ireqs;
    cbus_resp_t [NUM-1:0]  iresps;
    cbus_req_t             oreq;
    cbus_resp_t            oresp;
    logic                  busy;
    logic [IDX_W-1:0]      grant_idx;
    logic                  err;

    cbus_req_t  tb_req [NUM];
    cbus_resp_t rsp_l  [NUM];

    int        n_checks = 0;
    int        n_errors = 0;
    int        q_grant[$];
    exp_beat_t q_beat[$];
    int        exp_g;
    exp_beat_t exp_b;
    logic      prev_busy;
    int        gcnt [NUM];

    cbus_rr_arbiter #(.NUM_INPUTS(NUM)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx),
        .err       (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            ireqs[NUM-1-i] = tb_req[i];
            rsp_l[i]       = iresps[NUM-1-i];
        end
    end

    // Scoreboard monitor: retires predicted grants and response beats.
    always @(negedge clk) begin
        if (reset && busy && !prev_busy) begin
            n_checks++;
            if (q_grant.size() == 0) begin
                n_errors++;
                $display("FAIL grant_order: got grant %0d, none predicted", grant_idx);
            end else begin
                exp_g = q_grant.pop_front();
                if (int'(grant_idx) != exp_g) begin
                    n_errors++;
                    $display("FAIL grant_order: got grant %0d, expected %0d", grant_idx, exp_g);
                end
            end
        end
        for (int i = 0; i < NUM; i++) begin
            if (rsp_l[i].ready) begin
                n_checks++;
                if (q_beat.size() == 0) begin
                    n_errors++;
                    $display("FAIL resp_route: requester %0d got a beat, none predicted", i);
                end else begin
                    exp_b = q_beat.pop_front();
                    if (exp_b.idx != i || rsp_l[i].data !== exp_b.data) begin
                        n_errors++;
                        $display("FAIL resp_route: got req %0d data %h, expected req %0d data %h",
                                 i, rsp_l[i].data, exp_b.idx, exp_b.data);
                    end
                end
            end
        end
        prev_busy <= reset ? busy : 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input cbus_len_t len, input logic [ADDR_W-1:0] addr);
        tb_req[idx]        = '0;
        tb_req[idx].valid  = 1'b1;
        tb_req[idx].size   = MSIZE8;
        tb_req[idx].addr   = addr;
        tb_req[idx].len    = len;
    endtask

    task automatic beat(input logic last, input logic [DATA_W-1:0] data, input int idx);
        exp_beat_t eb;
        eb.idx  = idx;
        eb.data = data;
        q_beat.push_back(eb);
        oresp.ready = 1'b1;
        oresp.last  = last;
        oresp.data  = data;
        tick(1);
        oresp = '0;
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (!busy && k < 20) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_timeout: busy=%0b, expected 1", tag, busy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < NUM; i++) tb_req[i] = '0;
        oresp = '0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_req(0, MLEN1, 32'h100);
        oresp = '{ready: 1'b1, last: 1'b1, data: 64'hdead};
        tick(2);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0b, expected 0", err); end
        n_checks++;
        if (grant_idx !== '0) begin n_errors++; $display("FAIL reset_grant: got %0d, expected 0", grant_idx); end
        n_checks++;
        if (oreq !== '0) begin n_errors++; $display("FAIL reset_oreq: got %h, expected 0", oreq); end
        n_checks++;
        if (iresps !== '0) begin n_errors++; $display("FAIL reset_iresps: got %h, expected 0", iresps); end
        tb_req[0] = '0;
        oresp     = '0;
        reset     = 1'b1;
        tick(3);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_no_req: busy=%0b, expected 0", busy); end
    endtask

    task automatic test_single();
        set_req(1, MLEN1, 32'h2000);
        q_grant.push_back(1);
        #1;
        n_checks++;
        if (busy !== 1'b0 || oreq.valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_same_cycle: busy=%0b oreq.valid=%0b, expected 0 0", busy, oreq.valid);
        end
        tick(1);
        n_checks++;
        if (busy !== 1'b1 || grant_idx !== 1'b1) begin
            n_errors++;
            $display("FAIL single_latency: busy=%0b grant=%0d, expected 1 1", busy, grant_idx);
        end
        n_checks++;
        if (oreq.addr !== 32'h2000 || oreq.valid !== 1'b1) begin
            n_errors++;
            $display("FAIL single_oreq: addr=%h valid=%0b, expected 2000 1", oreq.addr, oreq.valid);
        end
        tick(2);
        n_checks++;
        if (rsp_l[1].ready !== 1'b0) begin
            n_errors++;
            $display("FAIL single_early_ready: got %0b, expected 0", rsp_l[1].ready);
        end
        begin
            exp_beat_t eb;
            eb.idx  = 1;
            eb.data = 64'h1234_5678_9abc_def0;
            q_beat.push_back(eb);
        end
        oresp = '{ready: 1'b1, last: 1'b1, data: 64'h1234_5678_9abc_def0};
        #1;
        n_checks++;
        if (rsp_l[1].data !== 64'h1234_5678_9abc_def0 || rsp_l[1].last !== 1'b1) begin
            n_errors++;
            $display("FAIL single_resp: data=%h last=%0b, expected 123456789abcdef0 1",
                     rsp_l[1].data, rsp_l[1].last);
        end
        n_checks++;
        if (rsp_l[0] !== '0) begin
            n_errors++;
            $display("FAIL single_other_resp: got %h, expected 0", rsp_l[0]);
        end
        tick(1);
        oresp = '0;
        tb_req[1].valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL single_end: busy=%0b err=%0b, expected 0 0", busy, err);
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b0;
        set_req(0, MLEN1, 32'h3000);
        set_req(1, MLEN1, 32'h4000);
        oresp = '0;
        gcnt[0] = 0;
        gcnt[1] = 0;
        tick(2);
        for (int k = 0; k < 4; k++) q_grant.push_back(k % 2);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_busy("rr");
            gcnt[int'(grant_idx)]++;
            beat(1'b1, 64'(32'hA000 + k), k % 2);
            if (k == 3) begin
                tb_req[0].valid = 1'b0;
                tb_req[1].valid = 1'b0;
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_errors++;
                $display("FAIL rr_idle_gap: busy=%0b after last, expected 0", busy);
            end
        end
        n_checks++;
        if (gcnt[0] != 2 || gcnt[1] != 2) begin
            n_errors++;
            $display("FAIL rr_fairness: counts %0d/%0d, expected 2/2", gcnt[0], gcnt[1]);
        end
    endtask

    task automatic test_burst();
        do_reset();
        set_req(0, MLEN4, 32'h5000);
        set_req(1, MLEN1, 32'h6000);
        q_grant.push_back(0);
        q_grant.push_back(1);
        wait_busy("burst");
        for (int b = 0; b < 4; b++) begin
            beat(b == 3, 64'(32'hB000 + b), 0);
            if (b < 3) begin
                n_checks++;
                if (busy !== 1'b1 || grant_idx !== 1'b0 || rsp_l[1] !== '0) begin
                    n_errors++;
                    $display("FAIL burst_hold: busy=%0b grant=%0d r1.ready=%0b, expected 1 0 0",
                             busy, grant_idx, rsp_l[1].ready);
                end
                tick(b + 1);
            end
        end
        tb_req[0].valid = 1'b0;
        n_checks++;
        if (dut.r_beat_cnt !== 8'd4) begin
            n_errors++;
            $display("FAIL burst_beats: beat_cnt=%0d, expected 4", dut.r_beat_cnt);
        end
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL burst_end: err=%0b busy=%0b, expected 0 0", err, busy);
        end
        wait_busy("burst_r1");
        beat(1'b1, 64'hC0DE, 1);
        tb_req[1].valid = 1'b0;
    endtask

    task automatic test_len_error();
        do_reset();
        set_req(0, MLEN2, 32'h7000);
        q_grant.push_back(0);
        wait_busy("lenerr");
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL lenerr_pre: err=%0b, expected 0", err); end
        beat(1'b1, 64'hE001, 0);
        tb_req[0].valid = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL lenerr_set: err=%0b, expected 1", err); end
        set_req(1, MLEN1, 32'h7100);
        q_grant.push_back(1);
        wait_busy("lenerr_clean");
        beat(1'b1, 64'hE002, 1);
        tb_req[1].valid = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL lenerr_sticky: err=%0b busy=%0b, expected 1 0", err, busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_req(0, MLEN1, 32'h8000);
        q_grant.push_back(0);
        wait_busy("arst_pre");
        beat(1'b1, 64'hF000, 0);
        tb_req[0].valid = 1'b0;
        set_req(1, MLEN4, 32'h8100);
        q_grant.push_back(1);
        wait_busy("arst_burst");
        beat(1'b0, 64'hF001, 1);
        begin
            exp_beat_t eb;
            eb.idx  = 1;
            eb.data = 64'hF002;
            q_beat.push_back(eb);
        end
        oresp = '{ready: 1'b1, last: 1'b0, data: 64'hF002};
        #6;
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || oreq.valid !== 1'b0 || iresps !== '0) begin
            n_errors++;
            $display("FAIL arst_immediate: busy=%0b oreq.valid=%0b, expected 0 0", busy, oreq.valid);
        end
        oresp = '0;
        set_req(0, MLEN1, 32'h8200);
        tick(2);
        q_grant.push_back(0);
        reset = 1'b1;
        tick(1);
        n_checks++;
        if (busy !== 1'b1 || grant_idx !== 1'b0) begin
            n_errors++;
            $display("FAIL arst_tie: busy=%0b grant=%0d, expected 1 0", busy, grant_idx);
        end
        beat(1'b1, 64'hF003, 0);
        tb_req[0].valid = 1'b0;
        tb_req[1].valid = 1'b0;
    endtask

    task automatic test_drop_valid();
        do_reset();
        set_req(0, MLEN1, 32'h9000);
        q_grant.push_back(0);
        wait_busy("drop");
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL drop_pre: err=%0b, expected 0", err); end
        tb_req[0].valid = 1'b0;
        tick(1);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b1 || oreq.valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drop_flag: err=%0b busy=%0b oreq.valid=%0b, expected 1 1 0",
                     err, busy, oreq.valid);
        end
        tick(2);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL drop_wait: busy=%0b, expected 1", busy); end
        beat(1'b1, 64'h9999, 0);
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_end: busy=%0b err=%0b, expected 0 1", busy, err);
        end
    endtask

    initial begin
        reset = 1'b0;
        oresp = '0;
        for (int i = 0; i < NUM; i++) tb_req[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_len_error();
        test_async_reset();
        test_drop_valid();
        tick(2);
        n_checks++;
        if (q_grant.size() != 0 || q_beat.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d grants and %0d beats left, expected 0 0",
                     q_grant.size(), q_beat.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
